// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : fifo_arb_pkg
// Brief  : Shared types, widths and helpers for the FIFO write-port arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // One spare bit so a count of MAX_BURST-1 compares cleanly for any MAX_BURST.
  function automatic int burst_cnt_width(input int max_burst);
    return clog2(max_burst) + 1;
  endfunction

  localparam int DEF_MAX_BURST = 4;
  localparam int BURST_CNT_W   = burst_cnt_width(DEF_MAX_BURST);

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module : rr_picker
// Brief  : Combinational winner selection for the write-port arbiter.
//          FIFO_ARB_FIXED_PRIO_EN selects lowest-index-wins instead of
//          round-robin.
// Rev    : 1.0  initial release
// ============================================================================
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    winner,
  output logic               any_valid
);

  assign any_valid = |req_valid;

`ifdef FIFO_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        winner = ID_W'(k);
      end
    end
  end
`else
  logic found;

  // Scan last_grant+1, last_grant+2, ... wrapping at NUM_REQ; first hit wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req_valid[j] && (j == ((int'(last_grant) + k) % NUM_REQ))) begin
          winner = ID_W'(j);
          found  = 1'b1;
        end
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : fifo_wr_arbiter
// Brief  : Shares the async-FIFO write port among NUM_REQ valid/ready
//          requesters with bounded bursts; FIFO_ARB_FIXED_PRIO_EN switches
//          the picker to fixed priority.
// Rev    : 1.0  initial release
// ============================================================================
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int Data_width = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_W       = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            Req_valid,
  input  logic [NUM_REQ*Data_width-1:0] Req_data,
  output logic [NUM_REQ-1:0]            Req_ready,
  input  logic                          Wfull,
  output logic                          Winc,
  output logic [Data_width-1:0]         Wrdata,
  output logic [ID_W-1:0]               Grant_id,
  output logic                          Busy
);

  localparam int CNT_W = burst_cnt_width(MAX_BURST);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic [ID_W-1:0]       pick_idx;
  logic                  pick_any;
  logic                  owner_valid;
  logic [Data_width-1:0] owner_data;
  logic                  xfer;
  logic                  last_word;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_valid  (Req_valid),
    .last_grant (last_grant_q),
    .winner     (pick_idx),
    .any_valid  (pick_any)
  );

  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_W'(i)) begin
        owner_valid = Req_valid[i];
        owner_data  = Req_data[i*Data_width +: Data_width];
      end
    end
  end

  // Full gating lives here so the FIFO never has to drop a write.
  assign xfer      = (state_q == ST_BURST) && owner_valid && !Wfull;
  assign last_word = (burst_cnt_q == CNT_W'(MAX_BURST - 1));

  always_comb begin
    Req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      Req_ready[i] = xfer && (grant_q == ID_W'(i));
    end
  end

  assign Winc     = xfer;
  assign Wrdata   = xfer ? owner_data : '0;
  assign Grant_id = grant_q;
  assign Busy     = (state_q == ST_BURST);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d     = pick_idx;
          burst_cnt_d = '0;
          state_d     = ST_BURST;
        end
      end
      ST_BURST: begin
        if (xfer) begin
          if (last_word) begin
            burst_cnt_d  = '0;
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end else if (!owner_valid && !Wfull) begin
          // Requester released the grant; a stall never releases it.
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_fifo_wr_arbiter
// Brief  : Directed scoreboard bench for fifo_wr_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int IW = 2;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [N-1:0]      Req_valid;
  logic [N*DW-1:0]   Req_data;
  logic [N-1:0]      Req_ready;
  logic              Wfull;
  logic              Winc;
  logic [DW-1:0]     Wrdata;
  logic [IW-1:0]     Grant_id;
  logic              Busy;

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .Data_width (DW),
    .MAX_BURST  (MB),
    .ID_W       (IW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Req_valid (Req_valid),
    .Req_data  (Req_data),
    .Req_ready (Req_ready),
    .Wfull     (Wfull),
    .Winc      (Winc),
    .Wrdata    (Wrdata),
    .Grant_id  (Grant_id),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] src_mem[N][32];
  int            src_len[N];
  int            src_ptr[N];
  logic          hold[N];
  int            total = 0;
  int            bad   = 0;

  logic          s_winc, s_busy, s_full;
  logic [IW-1:0] s_gid;
  logic [N-1:0]  s_ready, s_valid;
  logic [DW-1:0] s_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_ptr[i] < src_len[i]) begin
        Req_valid[i]        = !hold[i];
        Req_data[i*DW +: DW] = src_mem[i][src_ptr[i]];
      end else begin
        Req_valid[i]        = 1'b0;
        Req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic load(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      src_mem[i][src_len[i] + k] = DW'($urandom);
    end
    src_len[i] += n;
  endtask

  task automatic expect_words(input int i, input int from, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.id   = IW'(i);
      e.data = src_mem[i][from + k];
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      src_len[i] = 0;
      src_ptr[i] = 0;
      hold[i]    = 1'b0;
    end
    exp_q.delete();
  endtask

  // One clock: sample at negedge, score any write, advance requesters after posedge.
  task automatic tick();
    logic [N-1:0] acc;
    exp_t         e;
    @(negedge CLK);
    s_winc  = Winc;
    s_busy  = Busy;
    s_gid   = Grant_id;
    s_ready = Req_ready;
    s_valid = Req_valid;
    s_data  = Wrdata;
    s_full  = Wfull;
    chk("ready_onehot", 32'($countones(s_ready) <= 1), 32'd1);
    chk("ready_needs_valid_notfull", 32'(s_ready & ~(s_valid & {N{!s_full}})), 32'd0);
    chk("winc_is_xfer", 32'(s_winc), 32'(|(s_ready & s_valid)));
    if (s_winc === 1'b1) begin
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_grant", 32'(s_gid), 32'(e.id));
        chk("wr_data", 32'(s_data), 32'(e.data));
      end
    end else begin
      chk("wrdata_zero_no_write", 32'(s_data), 32'd0);
    end
    acc = s_ready & s_valid;
    @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) src_ptr[i]++;
    end
    drive();
  endtask

  task automatic do_reset();
    RST   = 1'b1;
    Wfull = 1'b0;
    clear_sources();
    drive();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_winc", 32'(Winc), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_gid", 32'(Grant_id), 32'd0);
    chk("rst_ready", 32'(Req_ready), 32'd0);
    chk("rst_wrdata", 32'(Wrdata), 32'd0);
    RST = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || Busy === 1'b1) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_all_written"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_in_budget"}, 32'(n < budget), 32'd1);
  endtask

  initial begin
    logic [9:0] pw;
    logic [9:0] pb;

    // 6 words from requester 0: 4-word burst, 1 arbitration cycle, 2 words, release.
    do_reset();
    load(0, 6);
    expect_words(0, 0, 6);
    drive();
    pw = 10'b0011011110;
    pb = 10'b0111011110;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("t1_winc_c%0d", k), 32'(s_winc), 32'(pw[k]));
      chk($sformatf("t1_busy_c%0d", k), 32'(s_busy), 32'(pb[k]));
      chk($sformatf("t1_gid_c%0d", k), 32'(s_gid), 32'd0);
    end
    chk("t1_all_written", 32'(exp_q.size()), 32'd0);

    // All four requesters with 8 words: grant order 0,1,2,3,0,1,2,3, 4 words each.
    do_reset();
    for (int i = 0; i < N; i++) load(i, 8);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) expect_words(i, r * 4, 4);
    end
    drive();
    drain("t2", 200);

    // Requester 2 stalls on Wfull for 5 cycles after its 2nd word.
    do_reset();
    load(2, 4);
    expect_words(2, 0, 4);
    drive();
    tick();
    chk("t3_arb_cycle_winc", 32'(s_winc), 32'd0);
    tick();
    tick();
    Wfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      hold[2] = (k == 1 || k == 2);
      drive();
      tick();
      chk($sformatf("t3_stall_winc_c%0d", k), 32'(s_winc), 32'd0);
      chk($sformatf("t3_stall_ready_c%0d", k), 32'(s_ready), 32'd0);
      chk($sformatf("t3_stall_gid_c%0d", k), 32'(s_gid), 32'd2);
      chk($sformatf("t3_stall_busy_c%0d", k), 32'(s_busy), 32'd1);
    end
    Wfull = 1'b0;
    drive();
    tick();
    chk("t3_resume_w3", 32'(s_winc), 32'd1);
    tick();
    chk("t3_resume_w4", 32'(s_winc), 32'd1);
    tick();
    chk("t3_capped_idle", 32'(s_busy), 32'd0);
    chk("t3_all_written", 32'(exp_q.size()), 32'd0);

    // Requester 1 sends one word and releases; pending 3 beats pending 0.
    do_reset();
    load(1, 1);
    expect_words(1, 0, 1);
    drive();
    tick();
    tick();
    chk("t4_word_winc", 32'(s_winc), 32'd1);
    chk("t4_word_gid", 32'(s_gid), 32'd1);
    load(0, 2);
    load(3, 2);
    expect_words(3, 0, 2);
    expect_words(0, 0, 2);
    drive();
    tick();
    chk("t4_release_busy", 32'(s_busy), 32'd1);
    chk("t4_release_winc", 32'(s_winc), 32'd0);
    tick();
    chk("t4_rearb_busy", 32'(s_busy), 32'd0);
    tick();
    chk("t4_next_gid", 32'(s_gid), 32'd3);
    chk("t4_next_winc", 32'(s_winc), 32'd1);
    drain("t4", 60);

    // Reset in the middle of a requester-1 burst.
    do_reset();
    load(1, 4);
    expect_words(1, 0, 4);
    drive();
    tick();
    tick();
    tick();
    RST = 1'b1;
    tick();
    chk("t5_pre_reset_winc", 32'(s_winc), 32'd1);
    clear_sources();
    drive();
    tick();
    chk("t5_rst_winc", 32'(s_winc), 32'd0);
    chk("t5_rst_busy", 32'(s_busy), 32'd0);
    chk("t5_rst_gid", 32'(s_gid), 32'd0);
    RST = 1'b0;
    load(0, 2);
    load(1, 2);
    load(3, 2);
    expect_words(0, 0, 2);
    expect_words(1, 0, 2);
    expect_words(3, 0, 2);
    drive();
    drain("t5", 60);

    // Requesters 0 and 2 held valid with 8 words each.
    do_reset();
    load(0, 8);
    load(2, 8);
`ifdef FIFO_ARB_FIXED_PRIO_EN
    expect_words(0, 0, 8);
    expect_words(2, 0, 8);
`else
    expect_words(0, 0, 4);
    expect_words(2, 0, 4);
    expect_words(0, 4, 4);
    expect_words(2, 4, 4);
`endif
    drive();
    drain("t6", 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
